bcd_display_mux: RTL and testbench

Downstream consumer of the BCD timer digit counters. Takes four BCD digits (units, tens, hundreds, thousands) plus the system error flag. Drives a time-multiplexed 4-digit seven-segment display with one shared segment bus and per-digit enables. Sits between the BCD counter chain and the board display pins.

---
 rtl/display_pkg.sv | 39 +++
 rtl/bcd_display_mux_if.sv | 20 ++
 rtl/bcd_to_7seg.sv | 28 ++
 rtl/bcd_display_mux.sv | 102 ++++++++++
 tb/tb_bcd_display_mux.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment display path.
// Segment patterns are stored active-high in {g,f,e,d,c,b,a} order;
// polarity is applied only at the output register.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIG_W      = 2;
    localparam int BCD_W      = 4;
    localparam int SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_E    = 7'h79;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
    localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

    // Registered display word: one segment pattern plus active-low enables.
    typedef struct packed {
        logic [SEG_W-1:0]      seg;
        logic [NUM_DIGITS-1:0] digit_n;
    } disp_t;

    // Active-low one-hot digit enable for a given scan index.
    function automatic logic [NUM_DIGITS-1:0] digit_sel_n(input logic [DIG_W-1:0] idx);
        logic [NUM_DIGITS-1:0] dn;
        dn      = '1;
        dn[idx] = 1'b0;
        return dn;
    endfunction

endpackage

// File: rtl/bcd_display_mux_if.sv
// Digit-value inputs and display-pin outputs of the display multiplexer.
// The master side feeds digits/flags; the slave side is the multiplexer.
interface bcd_display_mux_if;
    logic [15:0] bcd_in;
    logic        error;
    logic        blank;
    logic [6:0]  seg;
    logic [3:0]  digit_n;
    logic        frame_tick;

    modport master (
        output bcd_in, error, blank,
        input  seg, digit_n, frame_tick
    );

    modport slave (
        input  bcd_in, error, blank,
        output seg, digit_n, frame_tick
    );
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder, active-high {g..a}.
// Non-decimal codes A..F render as a dash so corrupt digits stay visible.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg
);

    // Table lookup; the default covers every illegal BCD code.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_mux.sv
// Time-multiplexed 4-digit seven-segment driver.
// A refresh counter steps the lit digit; the BCD word is sampled once per
// frame so all digits shown in a frame come from one coherent value.
// seg/digit_n are registered from the next-state scan index and snapshot,
// so they track the new digit one cycle after each scan tick.
module bcd_display_mux
    import display_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit LZ_BLANK       = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    bcd_display_mux_if.slave  bus
);

    localparam int                CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0]  IDX_MAX = DIG_W'(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]  SEG_DARK = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIG_W-1:0]  idx_q, idx_d;
    logic [15:0]       snap_q, snap_d;
    logic              scan_tick;
    logic              frame_wrap;

    logic [NUM_DIGITS-1:0][SEG_W-1:0] dec;
    logic [NUM_DIGITS-1:0]            lz_dark;

    disp_t disp_d, disp_q;
    logic [SEG_W-1:0] seg_pol;

    assign scan_tick  = (cnt_q == CNT_MAX);
    assign frame_wrap = scan_tick && (idx_q == IDX_MAX);

    // Next-state scan position and frame snapshot.
    always_comb begin
        cnt_d  = scan_tick ? '0 : cnt_q + 1'b1;
        idx_d  = scan_tick ? idx_q + 1'b1 : idx_q;
        snap_d = frame_wrap ? bus.bcd_in : snap_q;
    end

    // One decoder and one leading-zero test per digit, all fed from the
    // next-state snapshot so a fresh frame shows its new value at once.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        bcd_to_7seg u_dec (
            .bcd (snap_d[BCD_W*g +: BCD_W]),
            .seg (dec[g])
        );
        if (g == 0) begin : g_units
            assign lz_dark[g] = 1'b0;
        end else begin : g_upper
            assign lz_dark[g] = LZ_BLANK && (snap_d[15:BCD_W*g] == '0);
        end
    end

    // Pick what the next lit digit shows: blank beats error beats
    // leading-zero suppression beats the decoded digit.
    always_comb begin
        disp_d.seg     = SEG_OFF;
        disp_d.digit_n = '1;
        if (bus.blank) begin
            disp_d.seg     = SEG_OFF;
            disp_d.digit_n = '1;
        end else if (bus.error) begin
            disp_d.seg     = SEG_E;
            disp_d.digit_n = digit_sel_n(idx_d);
        end else if (lz_dark[idx_d]) begin
            disp_d.seg     = SEG_OFF;
            disp_d.digit_n = '1;
        end else begin
            disp_d.seg     = dec[idx_d];
            disp_d.digit_n = digit_sel_n(idx_d);
        end
    end

    assign seg_pol = SEG_ACTIVE_LOW ? ~disp_d.seg : disp_d.seg;

    // Scan state, snapshot and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            snap_q         <= '0;
            disp_q.seg     <= SEG_DARK;
            disp_q.digit_n <= '1;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            snap_q         <= snap_d;
            disp_q.seg     <= seg_pol;
            disp_q.digit_n <= disp_d.digit_n;
        end
    end

    assign bus.seg        = disp_q.seg;
    assign bus.digit_n    = disp_q.digit_n;
    assign bus.frame_tick = frame_wrap;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Scoreboard bench for bcd_display_mux. A reference model advances on each
// clock edge from the sampled inputs and queues the expected pin state; a
// monitor on the falling edge pops and compares.
module tb_bcd_display_mux;

    localparam int DIV = 4;

    logic clock;
    logic reset;

    bcd_display_mux_if bus ();

    bcd_display_mux #(
        .REFRESH_DIV    (DIV),
        .SEG_ACTIVE_LOW (1'b1),
        .LZ_BLANK       (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dn;
        logic       ft;
    } exp_t;

    exp_t        sb[$];
    int          nvec = 0;
    int          nerr = 0;
    int unsigned mt   = 0;
    logic [15:0] msnap = '0;
    logic [6:0]  glyph [16];

    initial begin
        glyph[0] = 7'h3F; glyph[1] = 7'h06; glyph[2] = 7'h5B; glyph[3] = 7'h4F;
        glyph[4] = 7'h66; glyph[5] = 7'h6D; glyph[6] = 7'h7D; glyph[7] = 7'h07;
        glyph[8] = 7'h7F; glyph[9] = 7'h6F;
        for (int i = 10; i < 16; i++) glyph[i] = 7'h40;
    end

    // Reference model: mt counts cycles since reset, so the lit digit is
    // simply (mt / DIV) % 4 and a frame boundary is the last cycle of digit 3.
    always @(posedge clock) begin
        exp_t        e;
        int          d;
        logic [3:0]  oh;
        logic [15:0] upper;
        if (reset) begin
            mt    = 0;
            msnap = '0;
            e.seg = 7'h7F;
            e.dn  = 4'hF;
        end else begin
            if ((mt % DIV) == DIV - 1 && ((mt / DIV) % 4) == 3) msnap = bus.bcd_in;
            mt++;
            d     = (mt / DIV) % 4;
            oh    = 4'b0001 << d;
            upper = msnap >> (4 * d);
            e.seg = 7'h00;
            e.dn  = 4'hF;
            if (bus.blank) begin
                e.seg = 7'h00;
            end else if (bus.error) begin
                e.seg = 7'h79;
                e.dn  = ~oh;
            end else if (d > 0 && upper == 16'h0) begin
                e.seg = 7'h00;
            end else begin
                e.seg = glyph[msnap[4*d +: 4]];
                e.dn  = ~oh;
            end
            e.seg = ~e.seg;
        end
        e.ft = ((mt % DIV) == DIV - 1) && (((mt / DIV) % 4) == 3);
        sb.push_back(e);
    end

    // Monitor: compare pins against the oldest queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            nvec++;
            if (bus.seg !== e.seg || bus.digit_n !== e.dn || bus.frame_tick !== e.ft) begin
                nerr++;
                $display("FAIL pins t=%0t got seg=%h dn=%h ft=%b want seg=%h dn=%h ft=%b",
                         $time, bus.seg, bus.digit_n, bus.frame_tick, e.seg, e.dn, e.ft);
            end
            nvec++;
            if ($countones(~bus.digit_n) > 1) begin
                nerr++;
                $display("FAIL onehot t=%0t got dn=%h want at most one low bit",
                         $time, bus.digit_n);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        int guard;
        logic [15:0] r;
        reset       = 1'b1;
        bus.bcd_in  = 16'h1234;
        bus.error   = 1'b0;
        bus.blank   = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(40);                               // zero frame, then 4/3/2/1

        bus.bcd_in = 16'h0007;  cyc(36);       // only units lit

        bus.bcd_in = 16'h0999;  cyc(22);       // mid-frame change below
        bus.bcd_in = 16'h1000;  cyc(36);

        bus.bcd_in = 16'h0005;  bus.error = 1'b1; cyc(20);
        bus.error  = 1'b0;      cyc(20);

        bus.bcd_in = 16'h000C;  cyc(24);       // dash on units
        bus.error  = 1'b1; bus.blank = 1'b1; cyc(12);
        bus.error  = 1'b0; bus.blank = 1'b0; cyc(4);

        bus.bcd_in = 16'h4321;  cyc(20);
        guard = 0;
        while (((mt / DIV) % 4) != 2 && guard < 4 * DIV) begin
            cyc(1);
            guard++;
        end
        reset = 1'b1; cyc(1);
        reset = 1'b0; cyc(50);                 // frame_tick spacing after reset

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = 16'($urandom);
                if ($urandom_range(0, 1) == 1) r = r >> (4 * $urandom_range(0, 3));
                bus.bcd_in = r;
            end
            bus.error = ($urandom_range(0, 15) == 0);
            bus.blank = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            cyc(1);
        end
        reset = 1'b0; bus.error = 1'b0; bus.blank = 1'b0;
        cyc(3);
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
